// File: rtl/bk_operand_recover.sv
// Two-stage ripple-borrow subtractor that recovers B = SUM - A from a Brent-Kung adder result,
// flagging SUM/A pairs the adder could not have produced and counting them (saturating).
module bk_operand_recover #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned SPLIT = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  localparam int unsigned HW = WIDTH - SPLIT;

  logic             s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_dlo_q, s1_dlo_d;
  logic             s1_bo_q, s1_bo_d;
  logic [HW:0]      s1_sum_hi_q, s1_sum_hi_d;
  logic [HW-1:0]    s1_a_hi_q, s1_a_hi_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             s2_adv;
  logic             err_xfer;
  logic [SPLIT:0]   lo_diff;
  logic [HW+1:0]    hi_diff;

  assign s2_adv   = !s2_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_adv;
  assign err_xfer = s2_valid_q & out_ready & out_err_q;

  assign lo_diff = {1'b0, in_sum[SPLIT-1:0]} - {1'b0, in_a[SPLIT-1:0]};
  // Two extension bits: bit HW+1 marks a negative difference, bit HW marks one >= 2^WIDTH.
  assign hi_diff = {1'b0, s1_sum_hi_q} - {2'b00, s1_a_hi_q} - {{(HW + 1){1'b0}}, s1_bo_q};

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_dlo_d    = s1_dlo_q;
    s1_bo_d     = s1_bo_q;
    s1_sum_hi_d = s1_sum_hi_q;
    s1_a_hi_d   = s1_a_hi_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_dlo_d    = lo_diff[SPLIT-1:0];
        s1_bo_d     = lo_diff[SPLIT];
        s1_sum_hi_d = in_sum[WIDTH:SPLIT];
        s1_a_hi_d   = in_a[WIDTH-1:SPLIT];
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    out_b_d    = out_b_q;
    out_err_d  = out_err_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_b_d   = {hi_diff[HW-1:0], s1_dlo_q};
        out_err_d = |hi_diff[HW+1:HW];
      end
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_xfer && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_dlo_q    <= '0;
      s1_bo_q     <= 1'b0;
      s1_sum_hi_q <= '0;
      s1_a_hi_q   <= '0;
      s2_valid_q  <= 1'b0;
      out_b_q     <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_dlo_q    <= s1_dlo_d;
      s1_bo_q     <= s1_bo_d;
      s1_sum_hi_q <= s1_sum_hi_d;
      s1_a_hi_q   <= s1_a_hi_d;
      s2_valid_q  <= s2_valid_d;
      out_b_q     <= out_b_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_b     = out_b_q;
  assign out_err   = out_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_bk_operand_recover.sv
// Directed bench for bk_operand_recover: an arithmetic scoreboard checked every cycle,
// plus literal expectations for latency, edge cases, saturation, clear and reset.
module tb_bk_operand_recover;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] in_sum = '0;
  logic [11:0] in_a = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_b;
  logic        out_err;
  logic [7:0]  err_count;
  logic        err_clr = 1'b0;

  bk_operand_recover #(.WIDTH(12), .SPLIT(6), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_b(out_b), .out_err(out_err),
    .err_count(err_count), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic err; logic [11:0] b; } res_t;

  res_t exp_q[$];
  int   model_cnt = 0;
  int   passed = 0;
  int   total = 0;
  int   n_out = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference: plain integer subtraction of the full operands.
  function automatic res_t model(input logic [12:0] s, input logic [11:0] a);
    res_t r;
    int   d;
    d     = int'(s) - int'(a);
    r.err = (d < 0) || (d >= 4096);
    r.b   = 12'(d);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_err_count", int'(err_count), 0);
      exp_q.delete();
      model_cnt = 0;
    end else begin
      chk("err_count", int'(err_count), model_cnt);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stale_output", 1, 0);
        end else begin
          chk("out_b", int'(out_b), int'(exp_q[0].b));
          chk("out_err", int'(out_err), int'(exp_q[0].err));
        end
      end
      if (err_clr) begin
        model_cnt = 0;
      end else if (out_valid && out_ready && exp_q.size() != 0) begin
        if (exp_q[0].err && model_cnt < 255) model_cnt++;
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_sum, in_a));
    end
  end

  task automatic send(input logic [12:0] s, input logic [11:0] a);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_sum   = s;
    in_a     = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic one(input logic [12:0] s, input logic [11:0] a,
                     input logic [11:0] b, input logic e);
    send(s, a);
    chk("lat_not_yet", int'(out_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", int'(out_valid), 1);
    chk("lit_b", int'(out_b), int'(b));
    chk("lit_err", int'(out_err), int'(e));
    @(posedge clk);
    #1;
  endtask

  logic [12:0] ts[8] = '{13'h0FFF, 13'h1000, 13'h0123, 13'h1FFF,
                         13'h0A5A, 13'h0003, 13'h1001, 13'h0800};
  logic [11:0] ta[8] = '{12'h001, 12'h800, 12'h023, 12'h000,
                         12'h05A, 12'h004, 12'h002, 12'h7FF};

  initial begin
    int base;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_b", int'(out_b), 0);
    chk("reset_out_err", int'(out_err), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_err_count", int'(err_count), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", int'(in_ready), 1);

    one(13'h1FFE, 12'hFFF, 12'hFFF, 1'b0);
    one(13'h0040, 12'h001, 12'h03F, 1'b0);
    one(13'h0000, 12'h000, 12'h000, 1'b0);
    chk("cnt_zero", int'(err_count), 0);
    one(13'h0005, 12'h006, 12'hFFF, 1'b1);
    chk("cnt_one", int'(err_count), 1);
    one(13'h1800, 12'h001, 12'h7FF, 1'b1);
    chk("cnt_two", int'(err_count), 2);

    base = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(ts[i], ta[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_out_valid", int'(out_valid), 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("stream_count", n_out - base, 8);
    chk("stream_drained", exp_q.size(), 0);

    for (int i = 0; i < 300; i++) send(13'h0000, 12'h001);
    repeat (4) @(posedge clk);
    #1;
    chk("cnt_saturated", int'(err_count), 255);

    send(13'h0005, 12'h006);
    @(posedge clk);
    #1;
    chk("clr_out_valid", int'(out_valid), 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("cnt_cleared", int'(err_count), 0);
    one(13'h0000, 12'h001, 12'hFFF, 1'b1);
    chk("cnt_after_clr", int'(err_count), 1);

    out_ready = 1'b0;
    send(13'h0100, 12'h001);
    send(13'h0200, 12'h002);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_err_count", int'(err_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("no_stale_valid", int'(out_valid), 0);
    one(13'h0010, 12'h008, 12'h008, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
